// File: rtl/yarvi_pkg.sv
// Shared definitions for the yarvi fetch stage.
package yarvi_pkg;

    // MSB index of the virtual address / PC
    localparam int VMSB = 31;

    // addi x0, x0, 0
    localparam logic [31:0] INSN_NOP = 32'h0000_0013;

    // Fetch-stage state encodings
    typedef enum logic [1:0] {
        FE_RESET = 2'b00,
        FE_RUN   = 2'b01,
        FE_FAULT = 2'b10
    } fe_state_e;

endpackage

// File: rtl/yarvi_imem.sv
module yarvi_imem #(
  parameter int IMEM_LOG2 = 12,
  parameter     INIT_FILE = "program.hex"
) (
  input  logic                 clock,
  input  logic [IMEM_LOG2-1:0] addr,
  output logic [31:0]          rdata
);

  logic [31:0] mem [0:(1<<IMEM_LOG2)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/yarvi_fetch.sv
// Instruction fetch stage: owns the fetch PC, drives the imem address and
// presents valid/pc/insn to the register-file stage with stall and restart.
module yarvi_fetch
    import yarvi_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h8000_0000,
    parameter int          IMEM_LOG2 = 12,
    parameter              INIT_FILE = "program.hex"
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          stall,
    input  logic          restart,
    input  logic [VMSB:0] restart_pc,
    output logic          fe_valid,
    output logic [VMSB:0] fe_pc,
    output logic [31:0]   fe_insn,
    output logic          fe_misaligned
);

    localparam logic [VMSB:0] RST_PC  = RESET_PC[VMSB:0];
    localparam logic [VMSB:0] PC_STEP = {{(VMSB-2){1'b0}}, 3'd4};

    fe_state_e     state_q;
    logic [VMSB:0] pc_q;
    logic          valid_q;
    logic          misal_q;
    logic [VMSB:0] fetch_addr;
    logic [31:0]   imem_rdata;
    logic          unused_addr_bits;

    // Address into the imem. pc_q always names the word whose read data is
    // currently in the imem register, so holding means re-reading pc_q. The
    // bubble right after reset re-reads pc_q too: RESET_PC was fetched while
    // leaving RESET but fe_pc only becomes valid one edge later.
    always_comb begin
        fetch_addr = pc_q + PC_STEP;
        if (restart) begin
            fetch_addr = restart_pc;
        end else if (state_q == FE_RESET) begin
            fetch_addr = RST_PC;
        end else if (stall || state_q == FE_FAULT || !valid_q) begin
            fetch_addr = pc_q;
        end
    end

    // Fetch FSM with registered valid/pc/misaligned outputs; restart beats every state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FE_RESET;
            pc_q    <= RST_PC;
            valid_q <= 1'b0;
            misal_q <= 1'b0;
        end else if (restart) begin
            pc_q    <= restart_pc;
            valid_q <= 1'b1;
            misal_q <= |restart_pc[1:0];
            state_q <= (|restart_pc[1:0]) ? FE_FAULT : FE_RUN;
        end else begin
            case (state_q)
                FE_RESET: begin
                    state_q <= FE_RUN;
                    pc_q    <= RST_PC;
                end
                FE_RUN: begin
                    if (!stall) begin
                        pc_q    <= fetch_addr;
                        valid_q <= 1'b1;
                    end
                end
                FE_FAULT: begin
                    state_q <= FE_FAULT;
                end
                default: begin
                    state_q <= FE_RESET;
                    valid_q <= 1'b0;
                    misal_q <= 1'b0;
                end
            endcase
        end
    end

    yarvi_imem #(
        .IMEM_LOG2 (IMEM_LOG2),
        .INIT_FILE (INIT_FILE)
    ) u_imem (
        .clock (clock),
        .addr  (fetch_addr[IMEM_LOG2+1:2]),
        .rdata (imem_rdata)
    );

    // Upper bits alias modulo memory depth; byte-offset bits only matter for the fault flag
    assign unused_addr_bits = ^{fetch_addr[VMSB:IMEM_LOG2+2], fetch_addr[1:0]};

    assign fe_valid      = valid_q;
    assign fe_pc         = pc_q;
    assign fe_misaligned = misal_q;
    // Bubbles and faulted fetches present a NOP instead of stale read data
    assign fe_insn       = (valid_q && !misal_q) ? imem_rdata : INSN_NOP;

endmodule

// File: tb/tb_yarvi_fetch.sv
// Directed testbench for yarvi_fetch.
module tb_yarvi_fetch;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        restart;
    logic [31:0] restart_pc;
    logic        fe_valid;
    logic [31:0] fe_pc;
    logic [31:0] fe_insn;
    logic        fe_misaligned;

    int n_cmp;
    int n_bad;

    logic        ev;
    logic        em;
    logic [31:0] ep;
    logic [31:0] ei;

    yarvi_fetch #(
        .RESET_PC  (64'h8000_0000),
        .IMEM_LOG2 (12),
        .INIT_FILE ("")
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall         (stall),
        .restart       (restart),
        .restart_pc    (restart_pc),
        .fe_valid      (fe_valid),
        .fe_pc         (fe_pc),
        .fe_insn       (fe_insn),
        .fe_misaligned (fe_misaligned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Program image: word 0 is addi x1,x0,5; every other word encodes its own index
    function automatic logic [31:0] model_insn(input logic [31:0] a);
        logic [11:0] idx;
        idx = a[13:2];
        if (idx == 12'd0) return 32'h0050_0093;
        return {8'hA5, idx, 12'h013};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        ev = 1'b0; ep = 32'h8000_0000; ei = 32'h0000_0013; em = 1'b0;
        n_cmp++;
        if ({fe_valid, fe_pc, fe_insn, fe_misaligned} !== {ev, ep, ei, em}) begin
            n_bad++;
            $display("FAIL reset_hold: got v=%0b pc=%h insn=%h mis=%0b want v=%0b pc=%h insn=%h mis=%0b",
                     fe_valid, fe_pc, fe_insn, fe_misaligned, ev, ep, ei, em);
        end
        reset_n = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            tick();
            ev = (e == 2); ep = 32'h8000_0000; ei = (e == 2) ? 32'h0050_0093 : 32'h0000_0013; em = 1'b0;
            n_cmp++;
            if ({fe_valid, fe_pc, fe_insn, fe_misaligned} !== {ev, ep, ei, em}) begin
                n_bad++;
                $display("FAIL reset_edge%0d: got v=%0b pc=%h insn=%h mis=%0b want v=%0b pc=%h insn=%h mis=%0b",
                         e, fe_valid, fe_pc, fe_insn, fe_misaligned, ev, ep, ei, em);
            end
        end
    endtask

    task automatic test_sequential();
        for (int k = 1; k < 8; k++) begin
            tick();
            ev = 1'b1; ep = 32'h8000_0000 + 32'(4 * k); ei = model_insn(ep); em = 1'b0;
            n_cmp++;
            if ({fe_valid, fe_pc, fe_insn, fe_misaligned} !== {ev, ep, ei, em}) begin
                n_bad++;
                $display("FAIL seq_%0d: got v=%0b pc=%h insn=%h mis=%0b want v=%0b pc=%h insn=%h mis=%0b",
                         k, fe_valid, fe_pc, fe_insn, fe_misaligned, ev, ep, ei, em);
            end
        end
    endtask

    task automatic test_stall();
        restart = 1'b1; restart_pc = 32'h8000_0008;
        tick();
        restart = 1'b0;
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) stall = 1'b0;
            tick();
            ev = 1'b1; ep = (k < 3) ? 32'h8000_0008 : 32'h8000_000C; ei = model_insn(ep); em = 1'b0;
            n_cmp++;
            if ({fe_valid, fe_pc, fe_insn, fe_misaligned} !== {ev, ep, ei, em}) begin
                n_bad++;
                $display("FAIL stall_%0d: got v=%0b pc=%h insn=%h mis=%0b want v=%0b pc=%h insn=%h mis=%0b",
                         k, fe_valid, fe_pc, fe_insn, fe_misaligned, ev, ep, ei, em);
            end
        end
    endtask

    task automatic test_restart_stall();
        restart = 1'b1; stall = 1'b1; restart_pc = 32'h8000_0100;
        tick();
        restart = 1'b0; stall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) tick();
            ev = 1'b1; ep = 32'h8000_0100 + 32'(4 * k); ei = model_insn(ep); em = 1'b0;
            n_cmp++;
            if ({fe_valid, fe_pc, fe_insn, fe_misaligned} !== {ev, ep, ei, em}) begin
                n_bad++;
                $display("FAIL restart_stall_%0d: got v=%0b pc=%h insn=%h mis=%0b want v=%0b pc=%h insn=%h mis=%0b",
                         k, fe_valid, fe_pc, fe_insn, fe_misaligned, ev, ep, ei, em);
            end
        end
    endtask

    task automatic test_misaligned();
        restart = 1'b1; restart_pc = 32'h8000_0102;
        tick();
        restart = 1'b0;
        for (int k = 0; k < 6; k++) begin
            stall = k[0];
            if (k > 0) tick();
            ev = 1'b1; ep = 32'h8000_0102; ei = 32'h0000_0013; em = 1'b1;
            n_cmp++;
            if ({fe_valid, fe_pc, fe_insn, fe_misaligned} !== {ev, ep, ei, em}) begin
                n_bad++;
                $display("FAIL misaligned_hold_%0d: got v=%0b pc=%h insn=%h mis=%0b want v=%0b pc=%h insn=%h mis=%0b",
                         k, fe_valid, fe_pc, fe_insn, fe_misaligned, ev, ep, ei, em);
            end
        end
        stall = 1'b0;
        restart = 1'b1; restart_pc = 32'h8000_0200;
        tick();
        restart = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) tick();
            ev = 1'b1; ep = 32'h8000_0200 + 32'(4 * k); ei = model_insn(ep); em = 1'b0;
            n_cmp++;
            if ({fe_valid, fe_pc, fe_insn, fe_misaligned} !== {ev, ep, ei, em}) begin
                n_bad++;
                $display("FAIL misaligned_exit_%0d: got v=%0b pc=%h insn=%h mis=%0b want v=%0b pc=%h insn=%h mis=%0b",
                         k, fe_valid, fe_pc, fe_insn, fe_misaligned, ev, ep, ei, em);
            end
        end
    endtask

    task automatic test_wrap_alias();
        logic [31:0] want [4];
        want[0] = 32'hFFFF_FFFC; want[1] = 32'h0000_0000;
        want[2] = 32'h8000_4000; want[3] = 32'h8000_4004;
        restart = 1'b1; restart_pc = 32'hFFFF_FFFC;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin restart = 1'b1; restart_pc = 32'h8000_4000; end
            tick();
            restart = 1'b0;
            ev = 1'b1; ep = want[k]; ei = model_insn(ep); em = 1'b0;
            n_cmp++;
            if ({fe_valid, fe_pc, fe_insn, fe_misaligned} !== {ev, ep, ei, em}) begin
                n_bad++;
                $display("FAIL wrap_alias_%0d: got v=%0b pc=%h insn=%h mis=%0b want v=%0b pc=%h insn=%h mis=%0b",
                         k, fe_valid, fe_pc, fe_insn, fe_misaligned, ev, ep, ei, em);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        reset_n = 1'b0;
        #1;
        ev = 1'b0; ep = 32'h8000_0000; ei = 32'h0000_0013; em = 1'b0;
        n_cmp++;
        if ({fe_valid, fe_pc, fe_insn, fe_misaligned} !== {ev, ep, ei, em}) begin
            n_bad++;
            $display("FAIL reset_mid_async: got v=%0b pc=%h insn=%h mis=%0b want v=%0b pc=%h insn=%h mis=%0b",
                     fe_valid, fe_pc, fe_insn, fe_misaligned, ev, ep, ei, em);
        end
        tick();
        reset_n = 1'b1;
        stall = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            if (e == 3) stall = 1'b0;
            tick();
            ev = (e >= 3); ep = (e == 4) ? 32'h8000_0004 : 32'h8000_0000;
            ei = (e >= 3) ? model_insn(ep) : 32'h0000_0013; em = 1'b0;
            n_cmp++;
            if ({fe_valid, fe_pc, fe_insn, fe_misaligned} !== {ev, ep, ei, em}) begin
                n_bad++;
                $display("FAIL reset_mid_edge%0d: got v=%0b pc=%h insn=%h mis=%0b want v=%0b pc=%h insn=%h mis=%0b",
                         e, fe_valid, fe_pc, fe_insn, fe_misaligned, ev, ep, ei, em);
            end
        end
    endtask

    task automatic test_restart_in_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        restart = 1'b1; restart_pc = 32'h8000_0040;
        for (int k = 0; k < 2; k++) begin
            tick();
            restart = 1'b0;
            ev = 1'b1; ep = 32'h8000_0040 + 32'(4 * k); ei = model_insn(ep); em = 1'b0;
            n_cmp++;
            if ({fe_valid, fe_pc, fe_insn, fe_misaligned} !== {ev, ep, ei, em}) begin
                n_bad++;
                $display("FAIL restart_in_reset_%0d: got v=%0b pc=%h insn=%h mis=%0b want v=%0b pc=%h insn=%h mis=%0b",
                         k, fe_valid, fe_pc, fe_insn, fe_misaligned, ev, ep, ei, em);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_n = 1'b0;
        stall = 1'b0;
        restart = 1'b0;
        restart_pc = 32'h0;
        for (int i = 0; i < 4096; i++) begin
            dut.u_imem.mem[i] = model_insn(32'(i) << 2);
        end
        test_reset();
        test_sequential();
        test_stall();
        test_restart_stall();
        test_misaligned();
        test_wrap_alias();
        test_reset_mid_run();
        test_restart_in_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
